// File: rtl/reg8.sv
// reg8: general-purpose storage register with a synchronous load strobe.
// q comes straight from the flops. Reset is asynchronous and active-high, and it
// takes priority over a load. With en low the register simply keeps its value.
module reg8 #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Storage flops: reset > load > hold (hold is the implicit else).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_reg8.sv
// tb_reg8: directed and randomized checks of reg8 against a behavioural model.
// The model holds one expected byte. On each rising edge it applies
// "reset wins, else en loads d, else keep". An asynchronous reset between
// edges forces the expected value at once.
module tb_reg8;

    localparam int unsigned W  = 8;
    localparam logic [W-1:0] RV = 8'h00;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] q;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] m_q;

    reg8 #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: q=%h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, update the model from the inputs present at that
    // edge, then compare just after it.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset)   m_q = RV;
        else if (en) m_q = d;
        #1;
        check(tag, q, m_q);
    endtask

    task automatic async_reset_pulse(input string tag);
        reset = 1'b1;
        m_q   = RV;
        #1;
        check(tag, q, m_q);
        reset = 1'b0;
    endtask

    logic [W-1:0] pats [4] = '{8'h00, 8'hFF, 8'hAA, 8'h55};

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        d     = '0;
        m_q   = '0;

        // 1. Async reset between edges, held across edges.
        #2;
        en = 1'b1;
        d  = 8'h09;
        reset = 1'b1;
        m_q = RV;
        #1;
        check("rst_immediate", q, m_q);
        tick("rst_hold_edge1");
        tick("rst_hold_edge2");
        @(negedge clk);
        reset = 1'b0;

        // 2. Loads.
        en = 1'b1; d = 8'h5C;
        tick("load_5c");
        d = 8'h11;
        tick("load_11");

        // 3. Hold.
        en = 1'b0; d = 8'h6C;
        tick("hold_6c");
        d = 8'h4C;
        tick("hold_4c");

        // 4. Mid-cycle data change: only the value at the edge is taken.
        en = 1'b1; d = 8'hA5;
        @(negedge clk);
        check("midcycle_before", q, m_q);
        d = 8'h3C;
        #2;
        check("midcycle_no_glitch", q, m_q);
        tick("midcycle_3c");

        // 5. Async reset while loading, then the first edge after release loads.
        d = 8'hFF;
        tick("preload_ff");
        d = 8'h12;
        async_reset_pulse("rst_while_loading");
        d = 8'h34;
        @(negedge clk);
        check("rst_release_hold", q, m_q);
        d = 8'h77;
        tick("load_after_rst");

        // 6. Boundary patterns.
        foreach (pats[i]) begin
            d = pats[i];
            tick("pattern");
        end

        // Randomized traffic: loads, holds, mid-cycle d changes and reset pulses.
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                async_reset_pulse("rand_async_rst");
            end
            @(negedge clk);
            check("rand_between_edges", q, m_q);
            if ($urandom_range(0, 1) == 1) d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) en = ~en;
            tick("rand_edge");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
